// File: rtl/bias_pkg.sv
// rtl/bias_pkg.sv - shared FSM encoding, default widths and clamp helper for bias update
package bias_pkg;

  localparam int DEF_DWIDTH = 16;
  localparam int DEF_FRAC   = 8;
  localparam int SAT_W      = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_RDWAIT = 3'd2,
    ST_CALC   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_FIN    = 3'd5
  } bias_state_t;

  // Clamp a sign-extended value into the signed range of a w-bit word.
  function automatic logic signed [SAT_W-1:0] sat_clamp(
    input logic signed [SAT_W-1:0] v,
    input int unsigned             w
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/bias_mac_sat.sv
// rtl/bias_mac_sat.sv - combinational lr*delta scaling and bias add; BIAS_SAT_EN clamps instead of wrapping
module bias_mac_sat
  import bias_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int FRAC   = DEF_FRAC
) (
  input  logic signed [DWIDTH-1:0] i_lr,
  input  logic signed [DWIDTH-1:0] i_delta,
  input  logic signed [DWIDTH-1:0] i_old,
  input  logic signed [DWIDTH-1:0] i_p,
  output logic signed [DWIDTH-1:0] o_p,
  output logic signed [DWIDTH-1:0] o_new
);

  logic signed [2*DWIDTH-1:0] w_prod;
  logic signed [2*DWIDTH-1:0] w_shift;
  logic signed [DWIDTH:0]     w_sum;

  assign w_prod  = (2*DWIDTH)'(i_lr) * (2*DWIDTH)'(i_delta);
  // Arithmetic shift of the full product floors toward negative infinity.
  assign w_shift = w_prod >>> FRAC;
  assign w_sum   = (DWIDTH+1)'(i_old) + (DWIDTH+1)'(i_p);

`ifdef BIAS_SAT_EN
  assign o_p   = DWIDTH'(sat_clamp(SAT_W'(w_shift), DWIDTH));
  assign o_new = DWIDTH'(sat_clamp(SAT_W'(w_sum), DWIDTH));
`else
  assign o_p   = DWIDTH'(w_shift);
  assign o_new = DWIDTH'(w_sum);
`endif

endmodule

// File: rtl/bias_update_engine.sv
// rtl/bias_update_engine.sv - sequential read-modify-write of NEURONS bias words (arith via bias_mac_sat, BIAS_SAT_EN)
module bias_update_engine
  import bias_pkg::*;
#(
  parameter int DWIDTH    = DEF_DWIDTH,
  parameter int FRAC      = DEF_FRAC,
  parameter int AWIDTH    = 10,
  parameter int NEURONS   = 16,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DWIDTH-1:0] lr,
  input  logic [DWIDTH-1:0] delta,
  input  logic              delta_valid,
  output logic              delta_ready,
  output logic              bram_en,
  output logic              bram_we,
  output logic [AWIDTH-1:0] bram_addr,
  input  logic [DWIDTH-1:0] bram_rdata,
  output logic [DWIDTH-1:0] bram_wdata,
  output logic              busy,
  output logic              done
);

  bias_state_t               r_state;
  logic [AWIDTH-1:0]         r_idx;
  logic signed [DWIDTH-1:0]  r_lr_q;
  logic signed [DWIDTH-1:0]  r_delta_q;
  logic signed [DWIDTH-1:0]  r_p;
  logic                      r_delta_ready;
  logic                      r_bram_en;
  logic                      r_bram_we;
  logic [AWIDTH-1:0]         r_bram_addr;
  logic [DWIDTH-1:0]         r_bram_wdata;
  logic                      r_busy;
  logic                      r_done;

  logic [AWIDTH-1:0]         w_addr;
  logic                      w_last;
  logic signed [DWIDTH-1:0]  w_p;
  logic signed [DWIDTH-1:0]  w_new;

  // Address wraps modulo 2^AWIDTH by construction of the adder width.
  assign w_addr = r_idx + AWIDTH'(BASE_ADDR);
  assign w_last = (r_idx == AWIDTH'(NEURONS - 1));

  bias_mac_sat #(
    .DWIDTH (DWIDTH),
    .FRAC   (FRAC)
  ) u_mac (
    .i_lr    (r_lr_q),
    .i_delta (r_delta_q),
    .i_old   (bram_rdata),
    .i_p     (r_p),
    .o_p     (w_p),
    .o_new   (w_new)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_lr_q        <= '0;
      r_delta_q     <= '0;
      r_p           <= '0;
      r_delta_ready <= 1'b0;
      r_bram_en     <= 1'b0;
      r_bram_we     <= 1'b0;
      r_bram_addr   <= '0;
      r_bram_wdata  <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_bram_en <= 1'b0;
      r_bram_we <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_lr_q        <= lr;
            r_idx         <= '0;
            r_busy        <= 1'b1;
            r_delta_ready <= 1'b1;
            r_state       <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (delta_valid) begin
            r_delta_q     <= delta;
            r_bram_en     <= 1'b1;
            r_bram_addr   <= w_addr;
            r_delta_ready <= 1'b0;
            r_state       <= ST_RDWAIT;
          end
        end
        ST_RDWAIT: begin
          r_p     <= w_p;
          r_state <= ST_CALC;
        end
        ST_CALC: begin
          // Read data returned by the BRAM is valid in this cycle.
          r_bram_wdata <= w_new;
          r_state      <= ST_WRITE;
        end
        ST_WRITE: begin
          r_bram_en   <= 1'b1;
          r_bram_we   <= 1'b1;
          r_bram_addr <= w_addr;
          if (w_last) begin
            r_state <= ST_FIN;
          end else begin
            r_idx         <= r_idx + 1'b1;
            r_delta_ready <= 1'b1;
            r_state       <= ST_REQ;
          end
        end
        ST_FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign delta_ready = r_delta_ready;
  assign bram_en     = r_bram_en;
  assign bram_we     = r_bram_we;
  assign bram_addr   = r_bram_addr;
  assign bram_wdata  = r_bram_wdata;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_bias_update_engine.sv
// tb/tb_bias_update_engine.sv - directed bench with BRAM model and arithmetic reference for bias_update_engine
module tb_bias_update_engine;

  localparam int DW   = 16;
  localparam int FR   = 8;
  localparam int AW   = 10;
  localparam int N    = 4;
  localparam int BASE = 1022;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] lr;
  logic [DW-1:0] delta;
  logic          delta_valid;
  logic          delta_ready;
  logic          bram_en;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_rdata;
  logic [DW-1:0] bram_wdata;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  bias_update_engine #(
    .DWIDTH(DW), .FRAC(FR), .AWIDTH(AW), .NEURONS(N), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .lr(lr), .delta(delta),
    .delta_valid(delta_valid), .delta_ready(delta_ready), .bram_en(bram_en),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_rdata(bram_rdata),
    .bram_wdata(bram_wdata), .busy(busy), .done(done)
  );

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (bram_en && bram_we) mem[bram_addr] <= bram_wdata;
    else if (bram_en) bram_rdata <= mem[bram_addr];
  end

  int   cyc = 0;
  logic hs_q = 1'b0;
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    hs_q <= delta_valid && delta_ready;
  end

  logic          drv_on;
  logic [DW-1:0] dvec [0:N-1];
  int            stall_at;
  int            stall_len;
  int            k;
  int            stl;

  // Presents delta k until it is accepted; optionally withholds one delta while ready is high.
  always @(negedge clk) begin
    if (!drv_on) begin
      k = 0; stl = 0; delta_valid = 1'b0; delta = '0;
    end else begin
      if (hs_q) k = k + 1;
      if (k < N) begin
        delta = dvec[k];
        delta_valid = 1'b1;
        if (k == stall_at && stl < stall_len && delta_ready) begin
          delta_valid = 1'b0;
          stl = stl + 1;
        end
      end else begin
        delta_valid = 1'b0;
      end
    end
  end

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  stall_seen = 0;
  int  done_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int i);
    return AW'(BASE + i);
  endfunction

  function automatic logic [DW-1:0] model(input logic [DW-1:0] old, input logic [DW-1:0] lrv,
                                          input logic [DW-1:0] d);
    longint p;
    longint s;
    p = (longint'($signed(lrv)) * longint'($signed(d))) >>> FR;
`ifdef BIAS_SAT_EN
    if (p > 32767) p = 32767;
    else if (p < -32768) p = -32768;
`else
    p = longint'($signed(p[15:0]));
`endif
    s = longint'($signed(old)) + p;
`ifdef BIAS_SAT_EN
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`endif
    return s[15:0];
  endfunction

  task automatic monitor();
    wr_t w;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (bram_en && bram_we) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with nothing expected", bram_addr, bram_wdata);
          end else begin
            w = exp_q.pop_front();
            check("wr_addr", bram_addr, w.a);
            check("wr_data", bram_wdata, w.d);
          end
        end
        check("ready_only_when_busy", delta_ready & ~busy, 0);
        if (delta_ready && !delta_valid) stall_seen++;
        if (done) done_pulses++;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_delta_ready"}, delta_ready, 0);
    check({tag, "_bram_en"}, bram_en, 0);
    check({tag, "_bram_we"}, bram_we, 0);
    check({tag, "_bram_addr"}, bram_addr, 0);
    check({tag, "_bram_wdata"}, bram_wdata, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic preload(input int i, input logic [DW-1:0] v);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = addr_of(i); ld_data = v;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic setup(input logic [DW-1:0] b0, input logic [DW-1:0] b1, input logic [DW-1:0] b2,
                       input logic [DW-1:0] b3, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic [DW-1:0] d2, input logic [DW-1:0] d3);
    preload(0, b0); preload(1, b1); preload(2, b2); preload(3, b3);
    dvec[0] = d0; dvec[1] = d1; dvec[2] = d2; dvec[3] = d3;
  endtask

  task automatic expect_pass(input logic [DW-1:0] lrv);
    for (int i = 0; i < N; i++) exp_q.push_back('{addr_of(i), model(mem[addr_of(i)], lrv, dvec[i])});
  endtask

  task automatic run_pass(input logic [DW-1:0] lrv, input int s_at, input int s_len,
                          input bit extra_start, output int dcyc, output int stalls);
    int t0;
    int ss0;
    int dp0;
    expect_pass(lrv);
    stall_at = s_at; stall_len = s_len;
    ss0 = stall_seen; dp0 = done_pulses;
    @(negedge clk);
    drv_on = 1'b1; start = 1'b1; lr = lrv; t0 = cyc;
    @(negedge clk);
    start = 1'b0; lr = ~lrv;
    dcyc = -1;
    for (int c = 0; c < 400; c++) begin
      start = extra_start && (c == 2);
      if (done) begin
        dcyc = cyc - t0;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (dcyc < 0) begin
      total++; bad++;
      $display("FAIL pass_timeout: done not seen within 400 cycles");
    end
    @(negedge clk);
    drv_on = 1'b0;
    stalls = stall_seen - ss0;
    check("exp_queue_drained", exp_q.size(), 0);
    check("done_pulse_count", done_pulses - dp0, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dc;
    int st;
    int t0;
    rst_n = 1'b0; start = 1'b0; lr = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    drv_on = 1'b0; stall_at = -1; stall_len = 0;
    for (int i = 0; i < N; i++) dvec[i] = '0;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    #1 check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic pass, addresses wrap from 0x3FE through 0x001.
    setup(16'h0200, 16'hFF00, 16'h0000, 16'h0100, 16'h0100, 16'h0100, 16'hFC00, 16'h0000);
    run_pass(16'h0040, -1, 0, 1'b0, dc, st);
    check("basic_done_cycle", dc, 18);
    check("basic_stall_cycles", st, 0);
    check("basic_bias0", mem[addr_of(0)], 16'h0240);
    check("basic_bias1", mem[addr_of(1)], 16'hFF40);
    check("basic_bias2", mem[addr_of(2)], 16'hFF00);
    check("basic_bias3", mem[addr_of(3)], 16'h0100);

    // Same pass with a 5-cycle producer stall before neuron 2.
    setup(16'h0200, 16'hFF00, 16'h0000, 16'h0100, 16'h0100, 16'h0100, 16'hFC00, 16'h0000);
    run_pass(16'h0040, 2, 5, 1'b0, dc, st);
    check("stall_done_cycle", dc, 23);
    check("stall_ready_cycles", st, 5);
    check("stall_bias0", mem[addr_of(0)], 16'h0240);
    check("stall_bias2", mem[addr_of(2)], 16'hFF00);

    // Sum overflow and large negative cases.
    setup(16'h7F00, 16'h0100, 16'h8000, 16'h7FF0, 16'h7FFF, 16'hFF00, 16'h8000, 16'h0020);
    run_pass(16'h0100, -1, 0, 1'b0, dc, st);
`ifdef BIAS_SAT_EN
    check("sum_sat_bias0", mem[addr_of(0)], 16'h7FFF);
    check("sum_sat_bias3", mem[addr_of(3)], 16'h7FFF);
`else
    check("sum_wrap_bias0", mem[addr_of(0)], 16'hFEFF);
    check("sum_wrap_bias3", mem[addr_of(3)], 16'h8010);
`endif

    // Product overflow.
    setup(16'h0000, 16'h0000, 16'h0123, 16'h0042, 16'h7FFF, 16'h8000, 16'h0000, 16'h0001);
    run_pass(16'h7FFF, -1, 0, 1'b0, dc, st);
`ifdef BIAS_SAT_EN
    check("prod_sat_bias0", mem[addr_of(0)], 16'h7FFF);
`else
    check("prod_wrap_bias0", mem[addr_of(0)], 16'hFF00);
`endif
    check("prod_zero_delta_bias2", mem[addr_of(2)], 16'h0123);

    // Flooring of negative products.
    setup(16'h0010, 16'h0000, 16'h0000, 16'h0005, 16'hFFFF, 16'h0001, 16'hFF01, 16'h0100);
    run_pass(16'h0001, -1, 0, 1'b0, dc, st);
    check("floor_bias0", mem[addr_of(0)], 16'h000F);
    check("floor_bias1", mem[addr_of(1)], 16'h0000);
    check("floor_bias2", mem[addr_of(2)], 16'hFFFF);
    check("floor_bias3", mem[addr_of(3)], 16'h0006);

    // Reset during the read of neuron 1.
    setup(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
    expect_pass(16'h0100);
    @(negedge clk);
    drv_on = 1'b1; start = 1'b1; lr = 16'h0100; t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 20 && (cyc - t0) != 6; c++) @(negedge clk);
    #1;
    check("rdwait_read_en", bram_en, 1);
    check("rdwait_read_addr", bram_addr, addr_of(1));
    rst_n = 1'b0;
    #1 check_zero("midreset");
    exp_q.delete();
    drv_on = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_bias0_written", mem[addr_of(0)], 16'h1211);
    check("midreset_bias1_untouched", mem[addr_of(1)], 16'h2222);
    check("midreset_bias2_untouched", mem[addr_of(2)], 16'h3333);
    rst_n = 1'b1;
    @(negedge clk);

    // Fresh pass after reset, with a spurious start while busy.
    run_pass(16'h0100, -1, 0, 1'b1, dc, st);
    check("restart_done_cycle", dc, 18);
    check("restart_bias0", mem[addr_of(0)], 16'h1311);
    check("restart_bias1", mem[addr_of(1)], 16'h2322);
    check("restart_bias3", mem[addr_of(3)], 16'h4544);
    repeat (10) @(negedge clk);
    check("restart_no_second_pass", exp_q.size(), 0);
    check("idle_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bias_update_engine.md
Name: bias_update_engine

Overview:
- Multi-neuron successor to the single-bias update path; applies bias_new = bias_old + lr * delta to NEURONS consecutive bias words held in a layer BRAM.
- Sits between the backprop delta generator (which streams one delta per neuron) and the layer's bias BRAM port. One pass runs per training step.
- Sequential read-modify-write of each bias word, with a valid/ready delta handshake and a runtime learning rate.
- Fixed-point Q(DWIDTH-FRAC).FRAC arithmetic throughout.

Parameters:
- DWIDTH, 16, data width of bias, delta and learning rate (signed)
- FRAC, 8, number of fractional bits
- AWIDTH, 10, BRAM address width
- NEURONS, 16, number of biases per pass (1..2^AWIDTH)
- BASE_ADDR, 0, BRAM address of bias 0

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a pass when idle
- lr  in  DWIDTH  signed learning rate, sampled on accepted start
- delta  in  DWIDTH  signed delta for the current neuron
- delta_valid  in  1  delta is valid
- delta_ready  out  1  engine accepts delta this cycle
- bram_en  out  1  BRAM enable
- bram_we  out  1  BRAM write enable
- bram_addr  out  AWIDTH  BRAM address
- bram_rdata  in  DWIDTH  BRAM read data, 1-cycle latency after bram_en with bram_we=0
- bram_wdata  out  DWIDTH  updated bias
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse after the last write

Behaviour:
- Reset (async, rst_n=0): state IDLE, idx=0. All outputs 0: delta_ready, bram_en, bram_we, bram_addr, bram_wdata, busy, done. lr_q and delta_q cleared.
- Reset mid-pass aborts immediately. No further BRAM write is issued. Biases already written stay written.
- FSM states IDLE, REQ, RDWAIT, CALC, WRITE, FIN.
  - IDLE: on start=1, latch lr into lr_q, idx=0, busy=1, go to REQ. start is ignored in every other state.
  - REQ: delta_ready=1. On delta_valid=1:
    - latch delta into delta_q;
    - assert bram_en=1, bram_we=0, bram_addr=BASE_ADDR+idx (mod 2^AWIDTH wrap);
    - go to RDWAIT.
    - Otherwise stay in REQ; stalls are unbounded.
  - RDWAIT: BRAM outputs data. Register p = (lr_q * delta_q) >>> FRAC. The full 2*DWIDTH product is shifted arithmetically, truncating toward negative infinity. Go to CALC.
  - CALC: compute s = bram_rdata + p at width DWIDTH+1 or wider; register the DWIDTH result (see Optional Feature). Go to WRITE.
  - WRITE: bram_en=1, bram_we=1, bram_addr=BASE_ADDR+idx, bram_wdata=result.
    - If idx==NEURONS-1, go to FIN.
    - Else idx++ and go to REQ.
  - FIN: done=1 for one cycle, busy=0, go to IDLE.
- bram_en and bram_we are high only in the cycles stated above; otherwise 0. bram_addr and bram_wdata hold their last value.
- Timing: with delta_valid tied high, each neuron takes exactly 4 cycles. The pass is 4*NEURONS cycles from the first REQ, plus 1 cycle in FIN. done is asserted on cycle 4*NEURONS+2 after the start cycle, counting the start cycle as 0.
- delta_ready is never high outside REQ. A delta presented outside REQ is not consumed.
- lr changes during a pass have no effect.
- NEURONS=1: a single REQ→WRITE sequence, then FIN.

Optional Feature:
- Macro: BIAS_SAT_EN.
- Defined: p is clamped to [-2^(DWIDTH-1), 2^(DWIDTH-1)-1] before registering. The sum s is clamped to the same range before writing.
- Undefined: p and s are truncated to their low DWIDTH bits (two's-complement wrap).

Decomposition:
- Shared package bias_pkg holds:
  - state encoding constants (IDLE..FIN);
  - default DWIDTH/FRAC values;
  - a saturate function (width-parametrised clamp of a wide signed value to DWIDTH).
- One sub-module: bias_mac_sat. It is combinational: lr, delta, old bias → new bias, with the shift and clamp. It is reused by a later weight-update engine.

Test Plan:
- FRAC=8, NEURONS=4, BRAM biases {0x0200,0xFF00,0x0000,0x0100}, lr=0x0040, deltas {0x0100,0x0100,0xFC00,0x0000}, valid always high → written {0x0240,0xFF40,0xFF00,0x0100}; done on cycle 18.
- Same stimulus with delta_valid low for 5 cycles before neuron 2 → same data written; done delayed by exactly 5 cycles; delta_ready high throughout the stall.
- Saturation with BIAS_SAT_EN: old=0x7F00, lr=0x0100, delta=0x7FFF → writes 0x7FFF. Same case without the macro → writes 0xFEFF.
- Product overflow: lr=0x7FFF, delta=0x7FFF, old=0x0000 → 0x7FFF with the macro; 0xFF00 without (0x3FFF00 truncated).
- Negative rounding: lr=0x0001, delta=0xFFFF, old=0x0010 → p=-1, writes 0x000F.
- rst_n pulled low during the RDWAIT of neuron 1 → no write to address 1; all outputs 0 at once. A new start after reset completes a full pass correctly. A start asserted while busy is ignored (done pulses exactly once).
